// File: rtl/gate_seq_pkg.sv
// Shared definitions for the gate vector sequencer.
//   state_t     : sequencer FSM states
//   G_*         : bit positions of each gate result inside gate_in
//   EXP_TABLE   : expected gate_in for each operand vector (index = {A,B})
//   exp_vec()   : table lookup helper
package gate_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int G_AND   = 0;
    localparam int G_OR    = 1;
    localparam int G_NOT_A = 2;
    localparam int G_NOT_B = 3;
    localparam int G_NOR   = 4;
    localparam int G_NAND  = 5;
    localparam int G_XOR   = 6;
    localparam int G_XNOR  = 7;

    localparam int NUM_VECS = 4;

    // Entry [v] is the expected gate_in when A=v[1], B=v[0].
    localparam logic [NUM_VECS-1:0][7:0] EXP_TABLE = {8'h83, 8'h6A, 8'h66, 8'hBC};

    function automatic logic [7:0] exp_vec(input logic [1:0] v);
        return EXP_TABLE[v];
    endfunction

endpackage

// File: rtl/gate_golden_model.sv
// Combinational reference gate block.
//   a, b     : gate operands
//   expected : 8-bit gate results in gate_in bit order
module gate_golden_model
    import gate_seq_pkg::*;
(
    input  logic       a,
    input  logic       b,
    output logic [7:0] expected
);

    always_comb begin
        expected          = '0;
        expected[G_AND]   = a & b;
        expected[G_OR]    = a | b;
        expected[G_NOT_A] = ~a;
        expected[G_NOT_B] = ~b;
        expected[G_NOR]   = ~(a | b);
        expected[G_NAND]  = ~(a & b);
        expected[G_XOR]   = a ^ b;
        expected[G_XNOR]  = ~(a ^ b);
    end

endmodule

// File: rtl/gate_vector_sequencer.sv
// Drives the four 2-bit operand vectors into an external gate block, holds
// each for a programmable number of cycles, then compares the returned
// gate results against a golden model and accumulates error status.
//   clk, rst    : clock, synchronous active-high reset
//   start       : run request (accepted in IDLE only)
//   hold_cycles : drive cycles per vector, 0 treated as 1, latched at start
//   gate_in     : gate results from the block under test
//   A, B        : registered operands
//   busy        : high in DRIVE and CHECK
//   done        : one-cycle pulse in DONE
//   pass        : last completed run had no failing vectors
//   err_cnt     : failing vectors in the last/current run
//   err_mask    : OR of mismatch bits across the run
module gate_vector_sequencer
    import gate_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] hold_cycles,
    input  logic [7:0] gate_in,
    output logic       A,
    output logic       B,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [7:0] err_mask
);

    state_t     state, state_next;
    logic [1:0] vec, vec_next;
    logic [7:0] hold_lat, hold_cnt;
    logic [7:0] expected, mismatch;
    logic [2:0] err_cnt_upd;
    logic [7:0] hold_eff;
    logic       a_d, b_d, busy_d, done_d;

    // Golden model follows the vector register, so the compare in CHECK
    // sees the same operands currently presented on A/B.
    gate_golden_model u_golden (
        .a        (vec[1]),
        .b        (vec[0]),
        .expected (expected)
    );

    assign hold_eff    = (hold_cycles == 8'd0) ? 8'd1 : hold_cycles;
    assign mismatch    = gate_in ^ expected;
    assign err_cnt_upd = err_cnt + {2'b00, |mismatch};

    // State register plus datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            vec      <= '0;
            hold_lat <= '0;
            hold_cnt <= '0;
            err_cnt  <= '0;
            err_mask <= '0;
            pass     <= 1'b0;
            A        <= 1'b0;
            B        <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_next;
            vec   <= vec_next;
            A     <= a_d;
            B     <= b_d;
            busy  <= busy_d;
            done  <= done_d;
            case (state)
                IDLE: begin
                    if (start) begin
                        hold_lat <= hold_eff;
                        hold_cnt <= hold_eff;
                        err_cnt  <= '0;
                        err_mask <= '0;
                        pass     <= 1'b0;
                    end
                end
                DRIVE: hold_cnt <= hold_cnt - 8'd1;
                CHECK: begin
                    err_mask <= err_mask | mismatch;
                    err_cnt  <= err_cnt_upd;
                    if (vec == 2'd3) pass <= (err_cnt_upd == 3'd0);
                    else             hold_cnt <= hold_lat;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        vec_next   = vec;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = DRIVE;
                    vec_next   = 2'd0;
                end
            end
            // hold_cnt holds the drive cycles remaining including this one
            DRIVE: if (hold_cnt <= 8'd1) state_next = CHECK;
            CHECK: begin
                if (vec == 2'd3) begin
                    state_next = DONE;
                end else begin
                    state_next = DRIVE;
                    vec_next   = vec + 2'd1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode from the next state so every output comes from a flop
    always_comb begin
        a_d    = 1'b0;
        b_d    = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_next)
            DRIVE, CHECK: begin
                a_d    = vec_next[1];
                b_d    = vec_next[0];
                busy_d = 1'b1;
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gate_vector_sequencer.sv
module tb_gate_vector_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] hold_cycles;
    logic [7:0] gate_in;
    logic       A, B, busy, done, pass;
    logic [2:0] err_cnt;
    logic [7:0] err_mask;

    // fault knobs on the modelled gate block
    logic f_xor0, f_nand1, f_nor0;

    int checks = 0;
    int errors = 0;

    int         run_cyc;
    int         run_dones;
    logic [1:0] ab_log [0:127];
    logic       pass_first;
    logic       done_pass;
    logic [2:0] done_cnt;
    logic [7:0] done_mask;

    always #5 clk = ~clk;

    gate_vector_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .hold_cycles (hold_cycles),
        .gate_in     (gate_in),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .err_cnt     (err_cnt),
        .err_mask    (err_mask)
    );

    // downstream gate block with optional stuck faults
    always_comb begin
        gate_in    = '0;
        gate_in[0] = A & B;
        gate_in[1] = A | B;
        gate_in[2] = ~A;
        gate_in[3] = ~B;
        gate_in[4] = f_nor0 ? 1'b0 : ~(A | B);
        gate_in[5] = f_nand1 ? 1'b1 : ~(A & B);
        gate_in[6] = f_xor0 ? 1'b0 : (A ^ B);
        gate_in[7] = ~(A ^ B);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a run, optionally keep start asserted while it runs, record
    // A/B per cycle, then watch a few idle cycles for stray done pulses.
    task automatic do_run(input logic [7:0] h, input bit spam);
        hold_cycles = h;
        start       = 1'b1;
        step();
        start       = spam;
        hold_cycles = ~h;
        run_cyc    = 1;
        run_dones  = 0;
        pass_first = pass;
        while (!done && run_cyc < 100) begin
            ab_log[run_cyc] = {A, B};
            step();
            run_cyc++;
        end
        start = 1'b0;
        if (!done) chk("done_timeout", 0, 1);
        else run_dones = 1;
        done_pass = pass;
        done_cnt  = err_cnt;
        done_mask = err_mask;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done) run_dones++;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; hold_cycles = 8'd1;
        f_xor0 = 1'b0; f_nand1 = 1'b0; f_nor0 = 1'b0;
        repeat (3) step();
        chk("rst_A", A, 0);
        chk("rst_B", B, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_cnt", err_cnt, 0);
        chk("rst_mask", err_mask, 0);
        rst = 1'b0;
        step();

        // clean run, H=1: vectors 00,01,10,11 for two cycles each
        do_run(8'd1, 1'b0);
        chk("h1_done_cycle", run_cyc, 9);
        for (int n = 1; n <= 8; n++) chk($sformatf("h1_ab%0d", n), ab_log[n], (n - 1) / 2);
        chk("h1_pass", done_pass, 1);
        chk("h1_cnt", done_cnt, 0);
        chk("h1_mask", done_mask, 8'h00);
        chk("h1_dones", run_dones, 1);
        chk("h1_idle_busy", busy, 0);
        chk("h1_pass_hold", pass, 1);

        // xor stuck at 0
        f_xor0 = 1'b1;
        do_run(8'd1, 1'b0);
        chk("xor_pass_mid", pass_first, 0);
        chk("xor_done_cycle", run_cyc, 9);
        chk("xor_cnt", done_cnt, 2);
        chk("xor_mask", done_mask, 8'h40);
        chk("xor_pass", done_pass, 0);
        chk("xor_cnt_hold", err_cnt, 2);
        chk("xor_mask_hold", err_mask, 8'h40);
        f_xor0 = 1'b0;

        // start held high through the run: ignored, fresh counters
        do_run(8'd1, 1'b1);
        chk("spam_done_cycle", run_cyc, 9);
        chk("spam_dones", run_dones, 1);
        chk("spam_cnt", done_cnt, 0);
        chk("spam_pass", done_pass, 1);

        // hold 0 behaves like hold 1
        do_run(8'd0, 1'b0);
        chk("h0_done_cycle", run_cyc, 9);

        // hold 3
        do_run(8'd3, 1'b0);
        chk("h3_done_cycle", run_cyc, 17);
        chk("h3_ab3", ab_log[3], 0);
        chk("h3_ab4", ab_log[4], 0);
        chk("h3_ab5", ab_log[5], 1);
        chk("h3_ab13", ab_log[13], 3);
        chk("h3_ab16", ab_log[16], 3);

        // nand stuck 1, nor stuck 0
        f_nand1 = 1'b1; f_nor0 = 1'b1;
        do_run(8'd1, 1'b0);
        chk("nn_cnt", done_cnt, 2);
        chk("nn_mask", done_mask, 8'h30);
        chk("nn_pass", done_pass, 0);
        f_nand1 = 1'b0; f_nor0 = 1'b0;

        // reset during vec2 DRIVE
        f_xor0 = 1'b1;
        hold_cycles = 8'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        chk("mid_ab", {A, B}, 2);
        chk("mid_cnt", err_cnt, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_A", A, 0);
        chk("mid_rst_B", B, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_pass", pass, 0);
        chk("mid_rst_cnt", err_cnt, 0);
        chk("mid_rst_mask", err_mask, 0);
        run_dones = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done) run_dones++;
        end
        chk("mid_no_done", run_dones, 0);
        chk("mid_idle_busy", busy, 0);
        f_xor0 = 1'b0;
        do_run(8'd1, 1'b0);
        chk("post_done_cycle", run_cyc, 9);
        chk("post_pass", done_pass, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_vector_sequencer.md
GATE_VECTOR_SEQUENCER -- requirements
Module: gate_vector_sequencer

Interface
REQ-001 SHALL have a single clock and synchronous, active-high reset: clk, rising edge; rst is synchronous and active-high.
REQ-002 Port: clk  input  1  system clock.
REQ-003 Port: rst  input  1  synchronous active-high reset.
REQ-004 Port: start  input  1  run request, sampled in IDLE only.
REQ-005 Port: hold_cycles  input  8  cycles each vector is driven before checking; 0 treated as 1; sampled at start.
REQ-006 Port: gate_in  input  8  gate results from the downstream gate block: bit0 and, bit1 or, bit2 not_a, bit3 not_b, bit4 nor, bit5 nand, bit6 xor, bit7 xnor.
REQ-007 Port: A  output  1  gate operand A, registered.
REQ-008 Port: B  output  1  gate operand B, registered.
REQ-009 Port: busy  output  1  high in DRIVE and CHECK.
REQ-010 Port: done  output  1  one-cycle pulse at run end.
REQ-011 Port: pass  output  1  high when the last completed run had err_cnt=0.
REQ-012 Port: err_cnt  output  3  count of failing vectors in the last or current run (0..4).
REQ-013 Port: err_mask  output  8  OR of mismatch bits across the run, same bit order as gate_in.

Function
REQ-014 SHALL implement the FSM states IDLE, DRIVE, CHECK, DONE.
REQ-015 IDLE: A=B=0, busy=0; start=1 at an edge SHALL clear err_cnt/err_mask/pass, latch hold (max(hold_cycles,1)), set vec=0, and enter DRIVE.
REQ-016 DRIVE: A=vec[1], B=vec[0]; hold counter SHALL load the latched hold on entry and decrement each cycle; after exactly H DRIVE cycles SHALL go to CHECK.
REQ-017 CHECK (1 cycle): A/B unchanged; mismatch = gate_in XOR expected[vec]; err_mask |= mismatch; err_cnt += 1 if mismatch != 0.
REQ-018 Expected table: vec0 (AB=00)=0xBC, vec1 (01)=0x66, vec2 (10)=0x6A, vec3 (11)=0x83.
REQ-019 CHECK with vec<3 SHALL go to DRIVE with vec+1; with vec=3 SHALL go to DONE.
REQ-020 DONE (1 cycle): done=1, pass=(err_cnt==0 after the final check), A=B=0; next state IDLE.
REQ-021 Timing: start sampled at edge k SHALL give DRIVE from cycle k+1 and done high in cycle k+1+4*(H+1).
REQ-022 start while busy or in DONE SHALL be ignored, with no restart or queuing.
REQ-023 hold_cycles changes during a run SHALL have no effect.
REQ-024 err_cnt, err_mask and pass SHALL hold their values after DONE until the next accepted start.
REQ-025 pass SHALL be 0 from an accepted start until DONE.

Reset
REQ-026 rst=1 at any edge SHALL force IDLE, A=0, B=0, busy=0, done=0, pass=0, err_cnt=0, err_mask=0, vec=0, hold counter=0.
REQ-027 Reset mid-run SHALL abort the run with no done pulse; rst has priority over start in the same cycle.

Structure
REQ-028 The shared package gate_seq_pkg SHALL hold the state enum, the gate_in bit-index constants and the 4-entry expected-value table.
REQ-029 Sub-module gate_golden_model SHALL be combinational, take (A,B) and produce the 8-bit expected vector; CHECK uses it instead of an inline table when instantiated.
REQ-030 All outputs SHALL be registered, with no combinational path from gate_in to any output.

Verification
REQ-031 Golden gate block connected, hold_cycles=1, start pulse -> A,B sequence 00,01,10,11 (2 cycles each incl. CHECK); done at k+9; pass=1, err_cnt=0, err_mask=0x00.
REQ-032 xor output forced 0 -> err_cnt=2 (vec1, vec2), err_mask=0x40, pass=0.
REQ-033 hold_cycles=0 -> identical timing to hold_cycles=1 (done at k+9); hold_cycles=3 -> each vector driven 3 cycles, done at k+17.
REQ-034 start reasserted in cycles k+2..k+8 -> ignored; exactly one done pulse; a second start after DONE -> fresh run with cleared counters.
REQ-035 rst asserted during vec2 DRIVE -> next cycle IDLE, A=B=0, all status 0, no done pulse; a subsequent start runs normally.
REQ-036 nand stuck-at-1 plus nor stuck-at-0 -> err_mask=0x30, err_cnt=2 (vec0 nor, vec3 nand), pass=0.
